// File: rtl/soc_io_pkg.sv
// Shared constants for the memory-mapped IO port: register offsets,
// STATUS bit positions, debounce state encoding and address helpers.
package soc_io_pkg;

    localparam logic [3:0] OFS_OPR1   = 4'h0;
    localparam logic [3:0] OFS_OPR2   = 4'h4;
    localparam logic [3:0] OFS_RESULT = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    localparam int unsigned STS_OPR1_CHG = 0;
    localparam int unsigned STS_OPR2_CHG = 1;
    localparam int unsigned STS_OPR1_CNT = 2;
    localparam int unsigned STS_OPR2_CNT = 3;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

    // True when the upper address bits match the window base.
    function automatic logic in_window(input logic [27:0] addr_hi, input logic [27:0] base_hi);
        return (addr_hi == base_hi);
    endfunction

    // Word-aligned register offset from the word-select bits.
    function automatic logic [3:0] reg_ofs(input logic [1:0] sel);
        return {sel, 2'b00};
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a per-bank debounce FSM. A new input
// value only commits after it has been seen unchanged for DEBOUNCE_CYCLES
// consecutive samples; any bounce restarts or abandons the count.
module io_debounce
    import soc_io_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] db,
    output logic             chg,
    output logic             counting
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] samp_r;
    logic [WIDTH-1:0] db_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             chg_r;
    logic             commit_s;
    db_state_e        state_r;
    db_state_e        state_s;

    // Next-state logic: bounce back, restart on mid-count change, commit or count.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            ST_STABLE: begin
                if (s2_r != db_r) begin
                    state_s = ST_COUNTING;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = ST_STABLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_COUNTING: begin
                if (s2_r == db_r) begin
                    state_s = ST_STABLE;
                    cnt_s   = CNT_ZERO;
                end else if (s2_r != samp_r) begin
                    state_s = ST_COUNTING;
                    cnt_s   = CNT_ONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = ST_STABLE;
                    cnt_s    = CNT_ZERO;
                    commit_s = 1'b1;
                end else begin
                    state_s = ST_COUNTING;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_STABLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Synchroniser chain, FSM state, counter, committed value and change pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r    <= {WIDTH{1'b0}};
            s2_r    <= {WIDTH{1'b0}};
            samp_r  <= {WIDTH{1'b0}};
            db_r    <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            chg_r   <= 1'b0;
            state_r <= ST_STABLE;
        end else begin
            s1_r    <= din;
            s2_r    <= s1_r;
            samp_r  <= s2_r;
            db_r    <= commit_s ? s2_r : db_r;
            cnt_r   <= cnt_s;
            chg_r   <= commit_s;
            state_r <= state_s;
        end
    end

    assign db       = db_r;
    assign chg      = chg_r;
    assign counting = (state_r == ST_COUNTING);

endmodule

// File: rtl/soc_io_port.sv
// Memory-mapped IO responder beside DMEM: debounced switch banks with
// sticky change flags, and the CPU-written result driving LEDs/seg7.
module soc_io_port
    import soc_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE         = 32'h0000_4000,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] ask_addr,
    input  logic [31:0] fetch_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic [7:0]  opr1_in,
    input  logic [7:0]  opr2_in,
    output logic [15:0] result
);

    logic [7:0]  opr1_db_s;
    logic [7:0]  opr2_db_s;
    logic        opr1_chg_s;
    logic        opr2_chg_s;
    logic        opr1_cnt_s;
    logic        opr2_cnt_s;
    logic [15:0] result_r;
    logic [1:0]  flag_r;
    logic [1:0]  clr_s;
    logic        result_we_s;
    logic [31:0] status_s;
    logic        unused_s;

    io_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_opr1 (
        .clk      (clk),
        .reset    (reset),
        .din      (opr1_in),
        .db       (opr1_db_s),
        .chg      (opr1_chg_s),
        .counting (opr1_cnt_s)
    );

    io_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_opr2 (
        .clk      (clk),
        .reset    (reset),
        .din      (opr2_in),
        .db       (opr2_db_s),
        .chg      (opr2_chg_s),
        .counting (opr2_cnt_s)
    );

    // Write decode: RESULT load enable and STATUS write-one-to-clear mask.
    always_comb begin
        result_we_s = 1'b0;
        clr_s       = 2'b00;
        if (we && in_window(ask_addr[31:4], IO_BASE[31:4])) begin
            result_we_s = (reg_ofs(ask_addr[3:2]) == OFS_RESULT);
            clr_s       = (reg_ofs(ask_addr[3:2]) == OFS_STATUS) ?
                          {wdata[STS_OPR2_CHG], wdata[STS_OPR1_CHG]} : 2'b00;
        end else begin
            result_we_s = 1'b0;
            clr_s       = 2'b00;
        end
    end

    // Result register and sticky change flags; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= 16'h0000;
            flag_r   <= 2'b00;
        end else begin
            result_r <= result_we_s ? wdata[15:0] : result_r;
            flag_r   <= (flag_r & ~clr_s) | {opr2_chg_s, opr1_chg_s};
        end
    end

    // Combinational read mux on fetch_addr; reads have no side effects.
    always_comb begin
        status_s = 32'h0000_0000;
        status_s[STS_OPR1_CHG] = flag_r[0];
        status_s[STS_OPR2_CHG] = flag_r[1];
        status_s[STS_OPR1_CNT] = opr1_cnt_s;
        status_s[STS_OPR2_CNT] = opr2_cnt_s;
        hit   = in_window(fetch_addr[31:4], IO_BASE[31:4]);
        rdata = 32'h0000_0000;
        if (hit) begin
            case (reg_ofs(fetch_addr[3:2]))
                OFS_OPR1:   rdata = {24'h00_0000, opr1_db_s};
                OFS_OPR2:   rdata = {24'h00_0000, opr2_db_s};
                OFS_RESULT: rdata = {16'h0000, result_r};
                OFS_STATUS: rdata = status_s;
                default:    rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign result   = result_r;
    assign unused_s = ^{ask_addr[1:0], fetch_addr[1:0], wdata[31:16]};

endmodule

// File: tb/tb_soc_io_port.sv
// Bench for soc_io_port with DEBOUNCE_CYCLES=4: register-access table,
// hand sequences for debounce/W1C/reset corners, and a random phase, all
// checked every cycle against a run-length model of the input filter.
module tb_soc_io_port;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] ask_addr = 32'h0;
    logic [31:0] fetch_addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        hit;
    logic [7:0]  opr1_in = 8'h00;
    logic [7:0]  opr2_in = 8'h00;
    logic [15:0] result;

    int n_vec = 0;
    int n_bad = 0;

    soc_io_port #(.IO_BASE(32'h0000_4000), .DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .ask_addr   (ask_addr),
        .fetch_addr (fetch_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .hit        (hit),
        .opr1_in    (opr1_in),
        .opr2_in    (opr2_in),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Reference model: input pipeline delay plus run length of identical samples.
    logic [7:0]  s1_m[2];
    logic [7:0]  s2_m[2];
    logic [7:0]  db_m[2];
    logic [7:0]  run_val_m[2];
    int          run_len_m[2];
    logic [7:0]  last_m[2];
    logic        chgp_m[2];
    logic        flag_m[2];
    logic [15:0] result_m;

    function automatic logic m_win(input logic [31:0] a);
        return ((a >> 4) == (32'h0000_4000 >> 4));
    endfunction

    task automatic model_edge();
        logic [7:0] raw[2];
        logic [7:0] smp;
        logic       wr;
        int         sel;
        raw[0] = opr1_in;
        raw[1] = opr2_in;
        wr  = we && m_win(ask_addr);
        sel = int'(ask_addr[3:2]);
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                s1_m[b] = 8'h00; s2_m[b] = 8'h00; db_m[b] = 8'h00;
                run_val_m[b] = 8'h00; run_len_m[b] = 0; last_m[b] = 8'h00;
                chgp_m[b] = 1'b0; flag_m[b] = 1'b0;
            end
            result_m = 16'h0000;
        end else begin
            for (int b = 0; b < 2; b++) begin
                flag_m[b] = (flag_m[b] && !(wr && sel == 3 && wdata[b])) || chgp_m[b];
                smp = s2_m[b];
                if (run_len_m[b] > 0 && smp == run_val_m[b]) run_len_m[b]++;
                else begin run_val_m[b] = smp; run_len_m[b] = 1; end
                chgp_m[b] = 1'b0;
                if (smp != db_m[b] && run_len_m[b] >= DC) begin
                    db_m[b] = smp;
                    chgp_m[b] = 1'b1;
                end
                last_m[b] = smp;
                s2_m[b] = s1_m[b];
                s1_m[b] = raw[b];
            end
            if (wr && sel == 2) result_m = wdata[15:0];
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!m_win(a)) return 32'h0;
        case (a[3:2])
            2'd0: return {24'h0, db_m[0]};
            2'd1: return {24'h0, db_m[1]};
            2'd2: return {16'h0, result_m};
            default: return {28'h0, last_m[1] != db_m[1], last_m[0] != db_m[0],
                             flag_m[1], flag_m[0]};
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then check outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cmp("model_rdata", rdata, model_rd(fetch_addr));
        cmp("model_hit", {31'h0, hit}, {31'h0, m_win(fetch_addr)});
        cmp("model_result", {16'h0, result}, {16'h0, result_m});
    endtask

    task automatic wr_status(input logic [31:0] v);
        we = 1'b1; ask_addr = 32'h0000_400C; wdata = v;
        tick();
        we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] ask;
        logic [31:0] wdata;
        logic [31:0] fetch;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1};
        tbl[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_4004, 32'h0000_0000, 1'b1};
        tbl[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_4008, 32'h0000_0000, 1'b1};
        tbl[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_400C, 32'h0000_0000, 1'b1};
        tbl[4]  = '{1'b1, 32'h0000_4008, 32'hDEAD_BEEF, 32'h0000_4008, 32'h0000_BEEF, 1'b1};
        tbl[5]  = '{1'b1, 32'h0000_4000, 32'h0000_00FF, 32'h0000_4000, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1'b1, 32'h0000_5008, 32'h0000_1234, 32'h0000_4008, 32'h0000_BEEF, 1'b1};
        tbl[7]  = '{1'b1, 32'h0000_400A, 32'hFFFF_00A5, 32'h0000_4009, 32'h0000_00A5, 1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3FFC, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_4010, 32'h0000_0000, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_4004, 32'h0000_0055, 32'h0000_4004, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_400C, 32'h0000_0003, 32'h0000_400C, 32'h0000_0000, 1'b1};
        tbl[12] = '{1'b1, 32'h0000_4008, 32'h0000_0000, 32'h0000_4008, 32'h0000_0000, 1'b1};

        // Reset held for two edges
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cmp("reset_result", {16'h0, result}, 32'h0);

        // Register access table
        for (int i = 0; i < 13; i++) begin
            we = tbl[i].we; ask_addr = tbl[i].ask; wdata = tbl[i].wdata;
            fetch_addr = tbl[i].fetch;
            tick();
            cmp("tbl_rdata", rdata, tbl[i].exp_rdata);
            cmp("tbl_hit", {31'h0, hit}, {31'h0, tbl[i].exp_hit});
        end
        we = 1'b0;

        // Same-cycle write and read of RESULT returns the old value
        we = 1'b1; ask_addr = 32'h0000_4008; wdata = 32'h0000_1111; fetch_addr = 32'h0000_4008;
        #1;
        cmp("wr_rd_old", rdata, 32'h0000_0000);
        tick();
        we = 1'b0;
        cmp("wr_rd_new", rdata, 32'h0000_1111);

        // Clean input: OPR1 commits after edge 5, flag then reads 1
        fetch_addr = 32'h0000_4000;
        opr1_in = 8'h5A;
        for (int k = 0; k <= 5; k++) begin
            tick();
            cmp("clean_opr1", rdata, (k >= 5) ? 32'h0000_005A : 32'h0000_0000);
        end
        fetch_addr = 32'h0000_400C;
        tick();
        cmp("clean_status", rdata, 32'h0000_0001);
        wr_status(32'h0000_0001);
        cmp("clean_clear", rdata, 32'h0000_0000);

        // Bounce on OPR2: FF for 2 cycles, 00 for 1, FF held
        fetch_addr = 32'h0000_4004;
        opr2_in = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            if (k == 2) opr2_in = 8'h00;
            if (k == 3) opr2_in = 8'hFF;
            tick();
            cmp("bounce_opr2", rdata, (k >= 8) ? 32'h0000_00FF : 32'h0000_0000);
        end
        fetch_addr = 32'h0000_400C;
        tick();
        cmp("bounce_status", rdata, 32'h0000_0002);
        wr_status(32'h0000_0002);
        for (int k = 0; k < 6; k++) begin
            tick();
            cmp("bounce_once", rdata, 32'h0000_0000);
        end

        // W1C race: clear written on the commit edge and the flag-set edge
        opr1_in = 8'h33;
        for (int k = 0; k <= 6; k++) begin
            if (k == 5) begin we = 1'b1; ask_addr = 32'h0000_400C; wdata = 32'h0000_0001; end
            tick();
        end
        we = 1'b0;
        cmp("race_set_wins", rdata, 32'h0000_0001);
        wr_status(32'h0000_0001);
        cmp("race_clear", rdata, 32'h0000_0000);

        // Reset in the second counting cycle discards the pending change
        we = 1'b1; ask_addr = 32'h0000_4008; wdata = 32'h0000_1234;
        tick();
        we = 1'b0;
        fetch_addr = 32'h0000_4000;
        opr1_in = 8'h0F;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("rst_mid_opr1", rdata, 32'h0000_0000);
        cmp("rst_mid_result", {16'h0, result}, 32'h0000_0000);
        for (int r = 0; r <= 5; r++) begin
            tick();
            cmp("rst_recommit", rdata, (r >= 5) ? 32'h0000_000F : 32'h0000_0000);
        end

        // Random phase against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) opr1_in = 8'($urandom);
            if ($urandom_range(0, 5) == 0) opr2_in = 8'($urandom);
            we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: ask_addr = 32'h0000_4000;
                1: ask_addr = 32'h0000_4004;
                2: ask_addr = 32'h0000_4008;
                3: ask_addr = 32'h0000_400C;
                4: ask_addr = 32'h0000_5008;
                default: ask_addr = $urandom;
            endcase
            wdata = $urandom;
            fetch_addr = ($urandom_range(0, 7) == 0) ? $urandom
                         : (32'h0000_4000 | 32'($urandom_range(0, 15)));
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
